// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block: stall patterns, exception codes
// and controller state encodings.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_IF_ID = 6'b000111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;

  localparam logic [31:0] EXC_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK = 32'h0000_0009;
  localparam logic [31:0] EXC_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP  = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET  = 32'h0000_000e;

  typedef enum logic [0:0] {
    StIdle,
    StRefill
  } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, exception flush/redirect sequencing with a refill
// mask, stall watchdog and stall-cycle performance counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter int unsigned REFILL_CYCLES = 3,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0]  RefillLoad = 4'(REFILL_CYCLES - 1);
  localparam logic [31:0] WdLast     = 32'(STALL_TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  refill_cnt_q;
  logic [31:0] wd_cnt_q;
  logic        accept;
  logic        stall_active;

  assign accept       = !rst && (state_q == StIdle) && (excepttype_i != 32'h0);
  assign stall_active = (stall != STALL_NONE);

  // A flush overrides every stall request; reset silences all outputs.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (accept) begin
      flush = 1'b1;
      case (excepttype_i)
        EXC_INT:  new_pc = INT_VECTOR;
        EXC_SYS, EXC_BREAK, EXC_RI, EXC_OV, EXC_TRAP: new_pc = EXC_VECTOR;
        EXC_ERET: new_pc = cp0_epc_i;
        default:  new_pc = EXC_VECTOR;
      endcase
    end else if (!rst) begin
      if (stallreq_mem)     stall = STALL_MEM;
      else if (stallreq_ex) stall = STALL_EX;
      else if (stallreq_id) stall = STALL_IF_ID;
      else if (stallreq_if) stall = STALL_IF_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      refill_cnt_q  <= 4'h0;
      wd_cnt_q      <= 32'h0;
      stall_timeout <= 1'b0;
      stall_cycles  <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StRefill;
            refill_cnt_q <= RefillLoad;
          end
        end
        StRefill: begin
          if (refill_cnt_q == 4'h0) state_q <= StIdle;
          else                      refill_cnt_q <= refill_cnt_q - 4'h1;
        end
        default: state_q <= StIdle;
      endcase

      if (flush || !stall_active) begin
        wd_cnt_q <= 32'h0;
      end else if (wd_cnt_q == WdLast) begin
        stall_timeout <= 1'b1;
      end else begin
        wd_cnt_q <= wd_cnt_q + 32'h1;
      end

      if (stall_active && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'h1;
      end
    end
  end

endmodule
